uart_cmd_regfile: RTL and testbench
===================================

Name: uart_cmd_regfile

Overview:
- Downstream consumer of the UART receive decoder's bulk write bus.
- Holds a REG_DEPTH x DATA_WIDTH command register bank written by host packets, and gives registered single-cycle read access to the PL control logic (motor/servo command consumers).
- A command watchdog zeroes a configurable safety window of registers when no host write arrives within WDT_CYCLES.

Parameters:
- REG_DEPTH, 256: number of 32-bit registers; LB_REG_DEPTH = $clog2(REG_DEPTH) is a localparam.
- DATA_WIDTH, 32: register width (localparam-fixed by the bus interface).
- WDT_CYCLES, 10_000_000: watchdog timeout in clk cycles (100 ms at 100 MHz); 0 disables the watchdog.
- SAFE_ADDR_LO, 0: first register cleared on timeout.
- SAFE_ADDR_HI, 7: last register cleared on timeout; must satisfy SAFE_ADDR_LO <= SAFE_ADDR_HI < REG_DEPTH.

Ports:
- clk  input  1  system clock; single clock domain.
- rstn  input  1  reset, asynchronous, active-low.
- bulk_rx  w_busif.slave  addr LB_REG_DEPTH / data DATA_WIDTH  write bus (addr, data, valid, ready).
- rd_req  input  1  read request.
- rd_addr  input  LB_REG_DEPTH  read address.
- rd_data  output  DATA_WIDTH  read data.
- rd_valid  output  1  rd_data valid pulse.
- wr_strobe  output  1  one-cycle pulse after each committed host write.
- wr_addr  output  LB_REG_DEPTH  address of the last committed write.
- timeout  output  1  high while commands are invalid (after reset or after expiry).
- timeout_cnt  output  8  saturating count of watchdog expiries.

Behaviour:
- Reset (async assert, sync release):
  - All registers 0; rd_data 0; rd_valid 0; wr_strobe 0; wr_addr 0.
  - timeout 1; timeout_cnt 0; watchdog counter 0; state ST_HOLD.
- FSM states: ST_RUN, ST_CLEAR, ST_HOLD.
- bulk_rx.ready: 1 in ST_RUN and ST_HOLD, 0 in ST_CLEAR. Accept = valid & ready.
- Write commit: on an accepted cycle N, reg[addr] <= data at edge N.
  - In N+1: wr_strobe = 1 and wr_addr = the written address.
  - Back-to-back accepts are allowed (one write per cycle).
- ST_RUN:
  - The watchdog counter increments each cycle and clears to 0 on any accept.
  - When counter == WDT_CYCLES-1 with no accept in that cycle: go to ST_CLEAR with clear_idx = SAFE_ADDR_LO.
  - Write in the expiry cycle: the write wins, the counter resets, the state stays ST_RUN.
- ST_CLEAR:
  - Each cycle reg[clear_idx] <= 0 and clear_idx increments; the sweep takes SAFE_ADDR_HI-SAFE_ADDR_LO+1 cycles.
  - After clearing SAFE_ADDR_HI: go to ST_HOLD, timeout <= 1, timeout_cnt <= timeout_cnt+1 (saturates at 255).
  - The bus is stalled (valid held by the master) and the write is accepted once in ST_HOLD.
- ST_HOLD:
  - On an accept: commit the write, timeout <= 0, counter <= 0, go to ST_RUN.
  - With no accept: stay in ST_HOLD indefinitely.
- WDT_CYCLES == 0:
  - Never enter ST_CLEAR.
  - After reset, the first write moves ST_HOLD to ST_RUN permanently; timeout goes low.
- Read port:
  - rd_req in cycle N gives rd_data = reg[rd_addr] and rd_valid = 1 in cycle N+1.
  - rd_valid is 0 when rd_req was 0; rd_data holds its last value.
  - A read and a write to the same address in the same cycle return the old value (read-before-write).
  - Reads are allowed in every state. A read during ST_CLEAR returns contents as of that edge; an already-swept address reads 0.
- Reset mid-sweep: immediate return to reset values. Partially cleared registers read 0 after reset.
- Storage: plain register array (no BRAM inference required); 256x32 fits a CMOD-A7 LUT budget.

Decomposition:
- Package uart_regfile_pkg holds:
  - typedef enum logic [1:0] regfile_state_t {ST_RUN, ST_CLEAR, ST_HOLD};
  - DATA_WIDTH = 32;
  - the default WDT_CYCLES constant.
- Sub-module cmd_watchdog (counter, expiry compare, WDT_CYCLES==0 disable).
  - Inputs: kick, enable.
  - Output: expire pulse.
- The FSM, sweep and register bank stay in the top module.

Test Plan (bench uses WDT_CYCLES=100, SAFE 0..7):
- Reset release with no writes -> timeout=1, ready=1, all reads 0; wait 500 cycles -> timeout_cnt stays 0 (no sweep from ST_HOLD).
- Write addr 3 = 0xDEADBEEF -> wr_strobe pulse next cycle with wr_addr=3, timeout=0; rd_req addr 3 one cycle later -> rd_data=0xDEADBEEF with rd_valid exactly one cycle after rd_req.
- Write addr 3=0x11 and addr 200=0x22, then idle 100 cycles -> ready low for 8 cycles, then timeout=1, timeout_cnt=1; reg3 reads 0, reg200 reads 0x22.
- Writes every 99 cycles for 2000 cycles -> timeout stays 0, no ready drop; a write landing exactly in the expiry cycle keeps ST_RUN.
- Same-cycle write 0x55 and read of addr 10 (old 0x44) -> rd_data=0x44; next read -> 0x55.
- Assert rstn low during the sweep at clear_idx=4 -> all outputs at reset values immediately (async), registers 0..7 read 0; 300 forced expiries -> timeout_cnt saturates at 255.

Source files
------------

// File: rtl/uart_regfile_pkg.sv
// ============================================================================
// Module   : uart_regfile_pkg
// Brief    : Shared types and constants for the UART command register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_regfile_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_CLEAR = 2'd1,
        ST_HOLD  = 2'd2
    } regfile_state_t;

    localparam int DATA_WIDTH         = 32;
    localparam int WDT_CYCLES_DEFAULT = 10_000_000;
    localparam int TIMEOUT_CNT_WIDTH  = 8;

    function automatic logic [TIMEOUT_CNT_WIDTH-1:0] sat_inc(
        input logic [TIMEOUT_CNT_WIDTH-1:0] value
    );
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/w_busif.sv
// ============================================================================
// Module   : w_busif
// Brief    : Valid/ready bulk write bus carrying one (addr, data) beat per cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface w_busif #(
    parameter int AW = 8,
    parameter int DW = 32
) ();

    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          valid;
    logic          ready;

    modport master (output addr, output data, output valid, input ready);
    modport slave  (input addr, input data, input valid, output ready);

endinterface

`default_nettype wire

// File: rtl/cmd_watchdog.sv
// ============================================================================
// Module   : cmd_watchdog
// Brief    : Host command watchdog; pulses expire after WDT_CYCLES idle cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmd_watchdog
    import uart_regfile_pkg::*;
#(
    parameter int WDT_CYCLES = WDT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rstn,
    input  logic kick,
    input  logic enable,
    output logic expire
);

    generate
        if (WDT_CYCLES == 0) begin : g_disabled
            logic unused_inputs;
            assign unused_inputs = ^{clk, rstn, kick, enable};
            assign expire        = 1'b0;
        end else begin : g_enabled
            localparam int              CNT_W  = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
            localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WDT_CYCLES - 1);

            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             at_last;

            assign at_last = (cnt_q == C_LAST);
            // A kick in the final cycle beats the expiry.
            assign expire  = enable & ~kick & at_last;

            always_comb begin
                cnt_d = cnt_q + 1'b1;
                if (!enable || kick || at_last) begin
                    cnt_d = '0;
                end
            end

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/uart_cmd_regfile.sv
// ============================================================================
// Module   : uart_cmd_regfile
// Brief    : Host-written command register bank with registered read port and
//            a watchdog that sweeps a safety window to zero on command loss.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_regfile
    import uart_regfile_pkg::*;
#(
    parameter  int REG_DEPTH    = 256,
    parameter  int WDT_CYCLES   = WDT_CYCLES_DEFAULT,
    parameter  int SAFE_ADDR_LO = 0,
    parameter  int SAFE_ADDR_HI = 7,
    localparam int LB_REG_DEPTH = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1
) (
    input  logic                         clk,
    input  logic                         rstn,
    w_busif.slave                        bulk_rx,
    input  logic                         rd_req,
    input  logic [LB_REG_DEPTH-1:0]      rd_addr,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         rd_valid,
    output logic                         wr_strobe,
    output logic [LB_REG_DEPTH-1:0]      wr_addr,
    output logic                         timeout,
    output logic [TIMEOUT_CNT_WIDTH-1:0] timeout_cnt
);

    localparam logic [LB_REG_DEPTH-1:0] C_SAFE_LO = LB_REG_DEPTH'(SAFE_ADDR_LO);
    localparam logic [LB_REG_DEPTH-1:0] C_SAFE_HI = LB_REG_DEPTH'(SAFE_ADDR_HI);

    regfile_state_t                 state_q;
    regfile_state_t                 state_d;
    logic [LB_REG_DEPTH-1:0]        clear_idx_q;
    logic [LB_REG_DEPTH-1:0]        clear_idx_d;
    logic                           timeout_q;
    logic                           timeout_d;
    logic [TIMEOUT_CNT_WIDTH-1:0]   timeout_cnt_q;
    logic [TIMEOUT_CNT_WIDTH-1:0]   timeout_cnt_d;

    logic [DATA_WIDTH-1:0]          rd_data_q;
    logic                           rd_valid_q;
    logic                           wr_strobe_q;
    logic [LB_REG_DEPTH-1:0]        wr_addr_q;

    logic                           bus_ready;
    logic                           accept;
    logic                           sweep_en;
    logic                           wdt_run;
    logic                           wdt_expire;
    logic [DATA_WIDTH-1:0]          reg_bank [REG_DEPTH];

    // The bus stalls only while the safety sweep owns the bank's write path.
    assign bus_ready     = (state_q != ST_CLEAR);
    assign bulk_rx.ready = bus_ready;
    assign accept        = bulk_rx.valid & bus_ready;
    assign wdt_run       = (state_q == ST_RUN);

    cmd_watchdog #(
        .WDT_CYCLES (WDT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rstn   (rstn),
        .kick   (accept),
        .enable (wdt_run),
        .expire (wdt_expire)
    );

    always_comb begin
        state_d       = state_q;
        clear_idx_d   = clear_idx_q;
        timeout_d     = timeout_q;
        timeout_cnt_d = timeout_cnt_q;
        sweep_en      = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (wdt_expire) begin
                    state_d     = ST_CLEAR;
                    clear_idx_d = C_SAFE_LO;
                end
            end
            ST_CLEAR: begin
                sweep_en = 1'b1;
                if (clear_idx_q == C_SAFE_HI) begin
                    state_d       = ST_HOLD;
                    timeout_d     = 1'b1;
                    timeout_cnt_d = sat_inc(timeout_cnt_q);
                end else begin
                    clear_idx_d = clear_idx_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    state_d   = ST_RUN;
                    timeout_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_HOLD;
            clear_idx_q   <= '0;
            timeout_q     <= 1'b1;
            timeout_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            clear_idx_q   <= clear_idx_d;
            timeout_q     <= timeout_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    // Per-entry flops keep the async reset simple and avoid a looped array reset.
    generate
        for (genvar k = 0; k < REG_DEPTH; k++) begin : g_reg
            logic [DATA_WIDTH-1:0] entry_q;
            logic                  wr_hit;
            logic                  clr_hit;

            assign wr_hit  = accept   && (bulk_rx.addr == LB_REG_DEPTH'(k));
            assign clr_hit = sweep_en && (clear_idx_q  == LB_REG_DEPTH'(k));

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    entry_q <= '0;
                end else if (wr_hit) begin
                    entry_q <= bulk_rx.data;
                end else if (clr_hit) begin
                    entry_q <= '0;
                end
            end

            assign reg_bank[k] = entry_q;
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            rd_valid_q  <= rd_req;
            wr_strobe_q <= accept;
            if (rd_req) begin
                rd_data_q <= reg_bank[rd_addr];
            end
            if (accept) begin
                wr_addr_q <= bulk_rx.addr;
            end
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign wr_strobe   = wr_strobe_q;
    assign wr_addr     = wr_addr_q;
    assign timeout     = timeout_q;
    assign timeout_cnt = timeout_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_regfile.sv
// ============================================================================
// Module   : tb_uart_cmd_regfile
// Brief    : Scoreboard bench for uart_cmd_regfile (WDT_CYCLES=100, window 0..7).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_cmd_regfile;
    import uart_regfile_pkg::*;

    localparam int LB  = 8;
    localparam int WDT = 100;

    typedef struct {
        logic [31:0] v;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rd_req = 1'b0;
    logic [LB-1:0] rd_addr = '0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        wr_strobe;
    logic [LB-1:0] wr_addr;
    logic        timeout;
    logic [7:0]  timeout_cnt;

    w_busif #(.AW(LB), .DW(32)) bus ();

    uart_cmd_regfile #(
        .REG_DEPTH    (256),
        .WDT_CYCLES   (WDT),
        .SAFE_ADDR_LO (0),
        .SAFE_ADDR_HI (7)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .bulk_rx     (bus),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .wr_strobe   (wr_strobe),
        .wr_addr     (wr_addr),
        .timeout     (timeout),
        .timeout_cnt (timeout_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t rq[$];
    exp_t wq[$];
    int   last_acc = 0;
    bit   watch = 1'b0;
    int   drops = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    always @(negedge clk) begin
        exp_t e;
        if (rstn) begin
            if (rd_valid) begin
                if (rq.size() == 0) begin
                    check("rd_unexpected", 32'd1, 32'd0);
                end else begin
                    e = rq.pop_front();
                    check("rd_data", rd_data, e.v);
                    check("rd_latency", 32'(cyc), 32'(e.cyc));
                end
            end
            if (wr_strobe) begin
                if (wq.size() == 0) begin
                    check("wr_unexpected", 32'd1, 32'd0);
                end else begin
                    e = wq.pop_front();
                    check("wr_addr", 32'(wr_addr), e.v);
                    check("wr_latency", 32'(cyc), 32'(e.cyc));
                end
            end
            if (watch && !bus.ready) drops++;
        end
    end

    task automatic do_write(input logic [LB-1:0] a, input logic [31:0] d);
        int   waited = 0;
        exp_t e;
        bus.addr  = a;
        bus.data  = d;
        bus.valid = 1'b1;
        @(negedge clk);
        while (!bus.ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.ready) begin
            check("write_accept_bound", 32'd0, 32'd1);
        end else begin
            e.v   = 32'(a);
            e.cyc = cyc + 1;
            wq.push_back(e);
            last_acc = cyc;
        end
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
    endtask

    task automatic do_read(input logic [LB-1:0] a, input logic [31:0] exp);
        exp_t e;
        rd_req  = 1'b1;
        rd_addr = a;
        e.v     = exp;
        e.cyc   = cyc + 1;
        rq.push_back(e);
        @(posedge clk);
        #1;
        rd_req = 1'b0;
    endtask

    task automatic wr_rd_same(input logic [LB-1:0] a, input logic [31:0] d, input logic [31:0] old);
        exp_t e;
        bus.addr  = a;
        bus.data  = d;
        bus.valid = 1'b1;
        rd_req    = 1'b1;
        rd_addr   = a;
        @(negedge clk);
        check("same_cycle_ready", 32'(bus.ready), 32'd1);
        e.v = 32'(a);    e.cyc = cyc + 1; wq.push_back(e);
        e.v = old;       e.cyc = cyc + 1; rq.push_back(e);
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        rd_req    = 1'b0;
    endtask

    // Waits for ready to drop; returns the cycle of the first low sample or -1.
    task automatic wait_ready_low(output int at);
        int n = 0;
        at = -1;
        @(negedge clk);
        while (bus.ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!bus.ready) at = cyc;
    endtask

    initial begin
        #2ms;
        $display("FAIL global_time_limit: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int s;
        int n;
        bus.valid = 1'b0;
        bus.addr  = '0;
        bus.data  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_timeout", 32'(timeout), 32'd1);
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_timeout_cnt", 32'(timeout_cnt), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        do_read(8'd0, 32'd0);
        do_read(8'd3, 32'd0);
        do_read(8'd255, 32'd0);
        repeat (500) @(posedge clk);
        #1;
        check("hold_no_sweep_cnt", 32'(timeout_cnt), 32'd0);
        check("hold_timeout", 32'(timeout), 32'd1);

        // First write leaves HOLD
        do_write(8'd3, 32'hDEADBEEF);
        check("first_write_timeout", 32'(timeout), 32'd0);
        do_read(8'd3, 32'hDEADBEEF);

        // Expiry and sweep of the safety window
        do_write(8'd3, 32'h11);
        do_write(8'd200, 32'h22);
        wait_ready_low(s);
        check("expiry_cycle", 32'(s), 32'(last_acc + 101));
        n = 0;
        while (!bus.ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("sweep_len", 32'(n), 32'd8);
        check("expired_timeout", 32'(timeout), 32'd1);
        check("expired_cnt", 32'(timeout_cnt), 32'd1);
        @(posedge clk);
        #1;
        do_read(8'd3, 32'd0);
        do_read(8'd200, 32'h22);
        do_read(8'd7, 32'd0);

        // Kept alive by writes every 99 cycles, then one in the expiry cycle
        watch = 1'b1;
        drops = 0;
        do_write(8'd20, 32'd0);
        for (int i = 1; i <= 20; i++) begin
            repeat (98) @(posedge clk);
            #1;
            do_write(8'd20, 32'(i));
        end
        check("keepalive_timeout", 32'(timeout), 32'd0);
        repeat (99) @(posedge clk);
        #1;
        do_write(8'd21, 32'h77);
        repeat (50) @(posedge clk);
        #1;
        check("keepalive_no_drop", 32'(drops), 32'd0);
        check("expiry_cycle_write_timeout", 32'(timeout), 32'd0);
        watch = 1'b0;

        // Read-before-write on a same-cycle collision
        do_write(8'd10, 32'h44);
        wr_rd_same(8'd10, 32'h55, 32'h44);
        do_read(8'd10, 32'h55);
        do_read(8'd21, 32'h77);

        // Async reset in the middle of a sweep
        for (int i = 0; i < 8; i++) do_write(LB'(i), 32'hA0 + 32'(i));
        wait_ready_low(s);
        check("presweep_cnt", 32'(timeout_cnt), 32'd1);
        check("presweep_timeout", 32'(timeout), 32'd0);
        @(posedge clk);
        #1;
        do_read(8'd0, 32'd0);
        do_read(8'd6, 32'hA6);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check("async_timeout", 32'(timeout), 32'd1);
        check("async_ready", 32'(bus.ready), 32'd1);
        check("async_cnt", 32'(timeout_cnt), 32'd0);
        check("async_rd_data", rd_data, 32'd0);
        check("async_rd_valid", 32'(rd_valid), 32'd0);
        check("async_wr_addr", 32'(wr_addr), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) do_read(LB'(i), 32'd0);
        do_read(8'd10, 32'd0);

        // Saturation of the expiry counter
        for (int i = 1; i <= 300; i++) begin
            do_write(8'd30, 32'(i));
            n = 0;
            @(negedge clk);
            while (!timeout && n < 200) begin
                n++;
                @(negedge clk);
            end
            check("sat_cnt", 32'(timeout_cnt), (i > 255) ? 32'd255 : 32'(i));
            @(posedge clk);
            #1;
        end

        repeat (5) @(posedge clk);
        #1;
        check("rq_drained", 32'(rq.size()), 32'd0);
        check("wq_drained", 32'(wq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
